// File: rtl/i2c_slave.sv
// Oversampled I2C target: 7-bit address, byte write/read with ACK handling.
// Optional clock stretching on read underrun: define I2C_SLAVE_STRETCH_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP} state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;
  logic       sda_oe;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [6:0] txsh;

`ifdef I2C_SLAVE_STRETCH_EN
  logic scl_oe, wait_tx;
  assign scl = scl_oe ? 1'b0 : 1'bz;
`else
  assign scl = 1'bz;
`endif
  assign sda = sda_oe ? 1'b0 : 1'bz;

  logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev, enter_tx;
  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_ev = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_ev  = scl_s & scl_q & ~sda_q & sda_s;
  // Falling edge that ends an ACK slot and begins a transmitted byte
  assign enter_tx = scl_fall & ((state == ADDR_ACK & sda_oe & rw) | (state == TX_ACK));

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 7'h00;
      txsh      <= 7'h7f;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      rw        <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      busy      <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oe    <= 1'b0;
      wait_tx   <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_ev) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        sda_oe    <= 1'b0;
        start_det <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oe    <= 1'b0;
        wait_tx   <= 1'b0;
`endif
      end else if (stop_ev) begin
        state    <= IDLE;
        bit_cnt  <= 3'd0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oe   <= 1'b0;
        wait_tx  <= 1'b0;
`endif
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= {shreg[5:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shreg == SLAVE_ADDR) begin
                state <= ADDR_ACK;
                rw    <= sda_s;
                busy  <= 1'b1;
              end else begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end
          // sda_oe doubles as the phase flag: first fall drives ACK, second ends it
          ADDR_ACK, RX_ACK: if (scl_fall) begin
            if (!sda_oe) sda_oe <= 1'b1;
            else begin
              sda_oe <= 1'b0;
              state  <= (state == ADDR_ACK && rw) ? TX : RX;
            end
          end
          RX: if (scl_rise) begin
            shreg   <= {shreg[5:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {shreg, sda_s};
              rx_valid <= 1'b1;
              state    <= RX_ACK;
            end
          end
          TX: begin
            if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
            else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                sda_oe <= ~txsh[6];
                txsh   <= {txsh[5:0], 1'b1};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise && sda_s) state <= WAIT_STOP;
            else if (scl_fall)     state <= TX;
          end
          default: ;
        endcase

        if (enter_tx) begin
          if (tx_valid) begin
            txsh     <= tx_data[6:0];
            sda_oe   <= ~tx_data[7];
            tx_ready <= 1'b1;
          end else begin
            txsh   <= 7'h7f;
            sda_oe <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            wait_tx <= 1'b1;
            scl_oe  <= 1'b1;
`endif
          end
        end
`ifdef I2C_SLAVE_STRETCH_EN
        // Hold SCL until data arrives; release one clk after bit 7 is on SDA
        if (wait_tx && tx_valid) begin
          txsh     <= tx_data[6:0];
          sda_oe   <= ~tx_data[7];
          tx_ready <= 1'b1;
          wait_tx  <= 1'b0;
        end
        if (scl_oe && !wait_tx) scl_oe <= 1'b0;
`endif
      end
    end
  end

endmodule
